bcd_to_binary: RTL

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

---
 rtl/bcd_to_binary_pkg.sv | 15 +
 rtl/bcd_to_binary_digit_adjust.sv | 12 +
 rtl/bcd_to_binary.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_to_binary_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } bcd_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX     = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd8;
    localparam logic [3:0] BCD_ADJ_VALUE     = 4'd3;

endpackage

// File: rtl/bcd_to_binary_digit_adjust.sv
// Per-digit correction for reverse double-dabble: a digit that reached 8 or
// more after a right shift had a "ten" shifted into it, so it is pulled back by 3.
module bcd_digit_adjust
    import bcd_to_binary_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESHOLD) ? (digit_in - BCD_ADJ_VALUE) : digit_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (shift right / subtract 3).
// Optional build macro BCD_TO_BINARY_CHECK_EN: reject operands holding a
// digit above 9 with o_error instead of converting them.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int DECIMAL_DIGITS = 6,
    parameter int OUTPUT_WIDTH   = 20
) (
    input  logic                        clock,
    input  logic                        reset_bcdcounter,
    input  logic                        i_start,
    input  logic [4*DECIMAL_DIGITS-1:0] i_bcd,
    output logic [OUTPUT_WIDTH-1:0]     o_binary,
    output logic                        o_dv,
    output logic                        o_busy,
    output logic                        o_overflow,
    output logic                        o_error
);

    localparam int BCD_W  = 4 * DECIMAL_DIGITS;
    localparam int WORK_W = BCD_W + OUTPUT_WIDTH;
    localparam int IDX_W  = $clog2(OUTPUT_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_WIDTH - 1);

    bcd_state_t        state;
    bcd_state_t        state_next;
    logic [WORK_W-1:0] work;
    logic [IDX_W-1:0]  idx;
    logic [BCD_W-1:0]  bcd_adjusted;
    logic              residual_nz;
    logic              start_invalid;
    logic              result_update;

    // One combinational corrector per BCD digit of the working register.
    for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adjust (
            .digit_in  (work[OUTPUT_WIDTH + 4*g +: 4]),
            .digit_out (bcd_adjusted[4*g +: 4])
        );
    end

    // Anything left in the BCD field after the last adjust does not fit the result.
    assign residual_nz = |work[WORK_W-1:OUTPUT_WIDTH];
    assign o_busy      = (state != IDLE);

`ifdef BCD_TO_BINARY_CHECK_EN
    logic err_pending;

    // Flag an operand containing any digit above 9.
    always_comb begin
        start_invalid = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (i_bcd[4*i +: 4] > BCD_DIGIT_MAX) start_invalid = 1'b1;
        end
    end

    assign result_update = !err_pending;

    // Remember the validation verdict at start and publish it with o_dv.
    always_ff @(posedge clock or posedge reset_bcdcounter) begin
        if (reset_bcdcounter) begin
            err_pending <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            if (state == IDLE && i_start) err_pending <= start_invalid;
            if (state == DONE)            o_error     <= err_pending;
        end
    end
`else
    assign start_invalid = 1'b0;
    assign result_update = 1'b1;
    assign o_error       = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = start_invalid ? DONE : SHIFT;
            SHIFT:   state_next = ADJUST;
            ADJUST:  state_next = (idx == LAST_IDX) ? DONE : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, working register, index and result outputs.
    always_ff @(posedge clock or posedge reset_bcdcounter) begin
        if (reset_bcdcounter) begin
            state      <= IDLE;
            work       <= '0;
            idx        <= '0;
            o_binary   <= '0;
            o_dv       <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state <= state_next;
            o_dv  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        work <= {i_bcd, {OUTPUT_WIDTH{1'b0}}};
                        idx  <= '0;
                    end
                end
                SHIFT: begin
                    work <= work >> 1;
                end
                ADJUST: begin
                    work <= {bcd_adjusted, work[OUTPUT_WIDTH-1:0]};
                    idx  <= idx + 1'b1;
                end
                DONE: begin
                    o_dv       <= 1'b1;
                    o_overflow <= result_update & residual_nz;
                    if (result_update) begin
                        o_binary <= residual_nz ? {OUTPUT_WIDTH{1'b1}} : work[OUTPUT_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
